gyro_spi_controller: RTL and testbench

- Sequences the team's byte-level SPI master to configure the PmodGYRO (L3G4200D) after reset, then periodically burst-read the six X/Y/Z rate bytes.
- Publishes signed 16-bit axis samples with a one-cycle valid strobe.
- Sits between the SPI byte engine and the user logic that consumes gyro samples; it is the sole owner of the engine.

---
 rtl/gyro_spi_controller.sv | 190 +++++++++++++++++++
 tb/tb_gyro_spi_controller.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gyro_spi_controller.sv
// Drives the shared SPI byte engine: configures the L3G4200D after reset, then
// periodically burst-reads the X/Y/Z rate registers and publishes signed samples.
module gyro_spi_controller #(
  parameter logic [19:0] STARTUP_CYCLES = 20'd100000,
  parameter logic [23:0] SAMPLE_PERIOD  = 24'd1000000,
  parameter logic [7:0]  SS_GAP         = 8'd16,
  parameter logic [19:0] TIMEOUT        = 20'd200000,
  parameter logic [7:0]  CFG1_DATA      = 8'h0F,
  parameter logic [7:0]  CFG4_DATA      = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               spi_done,
  input  logic [7:0]         spi_rx,
  output logic               spi_start,
  output logic [7:0]         spi_tx,
  output logic               spi_ss,
  output logic signed [15:0] x_rate,
  output logic signed [15:0] y_rate,
  output logic signed [15:0] z_rate,
  output logic               sample_valid,
  output logic               cfg_done,
  output logic               err
);

  localparam logic [19:0] GAP_LAST = {12'd0, SS_GAP} - 20'd1;
  localparam logic [23:0] PER_LAST = SAMPLE_PERIOD - 24'd1;

  typedef enum logic [2:0] {STARTUP, GAP, CFG_ADDR, CFG_DATA, IDLE, RD_ADDR, RD_BYTE} state_t;

  state_t      state, state_n;
  logic [19:0] cnt;
  logic [23:0] per_cnt;
  logic        cfg_idx;
  logic [2:0]  byte_idx;
  logic [7:0]  xl, xh, yl, yh, zl;

  logic       xfer, timeout_hit;
  logic       issue, frame_end, abort, capture, publish, cfg_next, cfg_finish;
  logic [7:0] tx_n;

  assign xfer        = (state == CFG_ADDR) || (state == CFG_DATA) ||
                       (state == RD_ADDR)  || (state == RD_BYTE);
  // A done arriving in the same cycle as expiry wins over the timeout
  assign timeout_hit = xfer && !spi_done && (cnt >= TIMEOUT);

  always_comb begin
    state_n    = state;
    issue      = 1'b0;
    tx_n       = spi_tx;
    frame_end  = 1'b0;
    abort      = 1'b0;
    capture    = 1'b0;
    publish    = 1'b0;
    cfg_next   = 1'b0;
    cfg_finish = 1'b0;
    if (timeout_hit) begin
      state_n = STARTUP;
      abort   = 1'b1;
    end else begin
      case (state)
        STARTUP: if (cnt >= STARTUP_CYCLES) begin
          state_n = CFG_ADDR;
          issue   = 1'b1;
          tx_n    = 8'h20;
        end
        CFG_ADDR: if (spi_done) begin
          state_n = CFG_DATA;
          issue   = 1'b1;
          tx_n    = cfg_idx ? CFG4_DATA : CFG1_DATA;
        end
        CFG_DATA: if (spi_done) begin
          state_n   = GAP;
          frame_end = 1'b1;
        end
        // The gap exit decides between the second config frame and idling
        GAP: if (cnt >= GAP_LAST) begin
          if (!cfg_done && !cfg_idx) begin
            state_n  = CFG_ADDR;
            issue    = 1'b1;
            tx_n     = 8'h23;
            cfg_next = 1'b1;
          end else begin
            state_n    = IDLE;
            cfg_finish = !cfg_done;
          end
        end
        IDLE: if (enable && (per_cnt >= PER_LAST)) begin
          state_n = RD_ADDR;
          issue   = 1'b1;
          tx_n    = 8'hE8;
        end
        RD_ADDR: if (spi_done) begin
          state_n = RD_BYTE;
          issue   = 1'b1;
          tx_n    = 8'h00;
        end
        RD_BYTE: if (spi_done) begin
          capture = 1'b1;
          if (byte_idx == 3'd5) begin
            state_n   = GAP;
            frame_end = 1'b1;
            publish   = 1'b1;
          end else begin
            issue = 1'b1;
            tx_n  = 8'h00;
          end
        end
        default: state_n = STARTUP;
      endcase
    end
  end

  // The first sample after configuration goes out as soon as reads are enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= STARTUP;
      cnt          <= '0;
      per_cnt      <= '0;
      cfg_idx      <= 1'b0;
      byte_idx     <= '0;
      xl           <= '0;
      xh           <= '0;
      yl           <= '0;
      yh           <= '0;
      zl           <= '0;
      spi_start    <= 1'b0;
      spi_tx       <= '0;
      spi_ss       <= 1'b1;
      x_rate       <= '0;
      y_rate       <= '0;
      z_rate       <= '0;
      sample_valid <= 1'b0;
      cfg_done     <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_n;
      spi_start    <= issue;
      sample_valid <= publish;
      if ((state_n != state) || issue)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + 20'd1;
      if (issue) begin
        spi_tx <= tx_n;
        spi_ss <= 1'b0;
      end else if (frame_end || abort) begin
        spi_ss <= 1'b1;
      end
      if (issue && (state_n == RD_ADDR))
        per_cnt <= '0;
      else if (cfg_finish)
        per_cnt <= PER_LAST;
      else if (per_cnt < PER_LAST)
        per_cnt <= per_cnt + 24'd1;
      if (state == STARTUP)
        cfg_idx <= 1'b0;
      else if (cfg_next)
        cfg_idx <= 1'b1;
      if (state == RD_ADDR)
        byte_idx <= '0;
      else if (capture)
        byte_idx <= byte_idx + 3'd1;
      if (capture) begin
        case (byte_idx)
          3'd0: xl <= spi_rx;
          3'd1: xh <= spi_rx;
          3'd2: yl <= spi_rx;
          3'd3: yh <= spi_rx;
          3'd4: zl <= spi_rx;
          default: ;
        endcase
      end
      // ZH is taken straight from the bus so all three axes update together
      if (publish) begin
        x_rate <= {xh, xl};
        y_rate <= {yh, yl};
        z_rate <= {spi_rx, zl};
      end
      if (abort) begin
        err      <= 1'b1;
        cfg_done <= 1'b0;
      end else if (cfg_finish) begin
        cfg_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gyro_spi_controller.sv
// Directed bench for gyro_spi_controller with a behavioural byte engine that
// answers each spi_start after a programmable delay from a queue of reply bytes.
module tb_gyro_spi_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        eng_done = 1'b0;
  logic        inj_done = 1'b0;
  logic        spi_done;
  logic [7:0]  spi_rx = 8'h00;
  logic        spi_start, spi_ss, sample_valid, cfg_done, err;
  logic [7:0]  spi_tx;
  logic [15:0] x_rate, y_rate, z_rate;

  assign spi_done = eng_done | inj_done;

  gyro_spi_controller #(
    .STARTUP_CYCLES(20'd10),
    .SAMPLE_PERIOD (24'd600),
    .SS_GAP        (8'd16),
    .TIMEOUT       (20'd100),
    .CFG1_DATA     (8'h0F),
    .CFG4_DATA     (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .spi_done    (spi_done),
    .spi_rx      (spi_rx),
    .spi_start   (spi_start),
    .spi_tx      (spi_tx),
    .spi_ss      (spi_ss),
    .x_rate      (x_rate),
    .y_rate      (y_rate),
    .z_rate      (z_rate),
    .sample_valid(sample_valid),
    .cfg_done    (cfg_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Byte engine: done arrives eng_delay cycles after the start, drop_sel=N skips the Nth start
  logic [7:0] rx_q[$];
  int eng_delay = 40;
  int drop_sel = 0;
  int dly = 0;
  bit busy = 1'b0;

  always @(negedge clk) begin
    eng_done = 1'b0;
    if (rst) begin
      busy = 1'b0;
    end else begin
      if (busy) begin
        if (dly == 1) begin
          eng_done = 1'b1;
          if (rx_q.size() > 0) spi_rx = rx_q.pop_front();
          else spi_rx = 8'hFF;
          busy = 1'b0;
        end else begin
          dly--;
        end
      end
      if (spi_start) begin
        if (drop_sel == 1) begin
          drop_sel = 0;
        end else begin
          if (drop_sel > 1) drop_sel--;
          busy = 1'b1;
          dly  = eng_delay;
        end
      end
    end
  end

  // Bus monitor: logs every start with its cycle, ss-high run lengths and bytes per frame
  int cyc = 0;
  logic [7:0] tx_q[$];
  int st_q[$];
  int gap_q[$];
  int fb_q[$];
  int ss_run = 0, fb = 0, valid_cnt = 0, err_cyc = -1;
  logic ss_prev = 1'b1, err_prev = 1'b0, valid_ss = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (spi_start) begin
      tx_q.push_back(spi_tx);
      st_q.push_back(cyc);
      if (!spi_ss) fb++;
    end
    if (spi_ss) begin
      if (!ss_prev) begin
        fb_q.push_back(fb);
        fb = 0;
      end
      ss_run++;
    end else begin
      if (ss_prev) gap_q.push_back(ss_run);
      ss_run = 0;
    end
    if (sample_valid) begin
      valid_cnt++;
      valid_ss = spi_ss;
    end
    if (err && !err_prev) err_cyc = cyc;
    ss_prev  = spi_ss;
    err_prev = err;
  end

  int total = 0;
  int bad = 0;
  int rel = 0;
  int en_cyc = 0;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] tx_at(input int i);
    if (i < tx_q.size()) return tx_q[i];
    return 8'hEE;
  endfunction

  function automatic int st_at(input int i);
    if (i < st_q.size()) return st_q[i];
    return -100000;
  endfunction

  task automatic wait_cfg(input int bound, input string tag);
    int i = 0;
    while (!cfg_done && i < bound) begin
      wait_cycles(1);
      i++;
    end
    check_output(tag, {31'd0, cfg_done}, 32'd1);
  endtask

  task automatic wait_valid(input int bound, input string tag);
    int i = 0;
    while (valid_cnt == 0 && i < bound) begin
      wait_cycles(1);
      i++;
    end
    check_output(tag, valid_cnt, 1);
  endtask

  task automatic clear_logs();
    tx_q.delete();
    st_q.delete();
    fb_q.delete();
    gap_q.delete();
  endtask

  task automatic check_cfg_seq(input string tag);
    check_output({tag, "_n"}, tx_q.size(), 4);
    check_output({tag, "_seq"}, {tx_at(0), tx_at(1), tx_at(2), tx_at(3)}, 32'h200F2300);
  endtask

  initial begin
    // Reset state
    wait_cycles(5);
    check_output("rst_ss", {31'd0, spi_ss}, 32'd1);
    check_output("rst_start", {31'd0, spi_start}, 32'd0);
    check_output("rst_tx", {24'd0, spi_tx}, 32'd0);
    check_output("rst_xyz", {x_rate, y_rate | z_rate}, 32'd0);
    check_output("rst_flags", {29'd0, sample_valid, cfg_done, err}, 32'd0);

    // Release and configure
    rel = cyc;
    clear_logs();
    rst = 1'b0;
    wait_cfg(500, "cfg_done");
    check_cfg_seq("cfg");
    check_output("start_latency", st_at(0) - rel, 11);
    check_output("byte_spacing", st_at(1) - st_at(0), 41);
    check_output("cfg_gap_n", gap_q.size(), 2);
    check_output("cfg_gap", (gap_q.size() > 1) ? gap_q[1] : -1, 16);
    check_output("cfg_err", {31'd0, err}, 32'd0);

    // First read frame
    wait_cycles(3);
    clear_logs();
    valid_cnt = 0;
    rx_q = '{8'h5A, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00, 8'h80};
    en_cyc = cyc;
    enable = 1'b1;
    wait_valid(600, "rd1_valid");
    check_output("rd1_x", {16'd0, x_rate}, 32'h1234);
    check_output("rd1_y", {16'd0, y_rate}, 32'hABCD);
    check_output("rd1_z", {16'd0, z_rate}, 32'h8000);
    check_output("rd1_ss_at_valid", {31'd0, valid_ss}, 32'd1);
    check_output("rd1_en_lat", st_at(0) - en_cyc, 1);
    check_output("rd1_addr", {24'd0, tx_at(0)}, 32'hE8);
    check_output("rd1_last_tx", {24'd0, tx_at(6)}, 32'h00);
    check_output("rd1_nbytes", tx_q.size(), 7);
    wait_cycles(2);
    check_output("rd1_valid_once", valid_cnt, 1);
    check_output("rd1_ss_bytes", (fb_q.size() > 0) ? fb_q[0] : -1, 7);

    // Second frame, one period later
    valid_cnt = 0;
    rx_q = '{8'h99, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    wait_valid(700, "rd2_valid");
    check_output("period", st_at(7) - st_at(0), 600);
    check_output("rd2_addr", {24'd0, tx_at(7)}, 32'hE8);
    check_output("rd2_x", {16'd0, x_rate}, 32'h2211);
    check_output("rd2_y", {16'd0, y_rate}, 32'h4433);
    check_output("rd2_z", {16'd0, z_rate}, 32'h6655);

    // Hold with enable low, stray done pulses while idle
    enable = 1'b0;
    clear_logs();
    valid_cnt = 0;
    wait_cycles(100);
    for (int k = 0; k < 3; k++) begin
      inj_done = 1'b1;
      wait_cycles(1);
      inj_done = 1'b0;
      wait_cycles(20);
    end
    wait_cycles(1837);
    check_output("hold_starts", tx_q.size(), 0);
    check_output("hold_valid", valid_cnt, 0);
    check_output("hold_x", {16'd0, x_rate}, 32'h2211);
    check_output("hold_err", {31'd0, err}, 32'd0);

    // Re-enable starts a frame on the next cycle
    rx_q = '{8'h00, 8'hEF, 8'hBE, 8'h01, 8'h00, 8'hFF, 8'h7F};
    en_cyc = cyc;
    enable = 1'b1;
    wait_valid(700, "rd3_valid");
    check_output("reen_lat", st_at(0) - en_cyc, 1);
    check_output("rd3_x", {16'd0, x_rate}, 32'hBEEF);
    check_output("rd3_y", {16'd0, y_rate}, 32'h0001);
    check_output("rd3_z", {16'd0, z_rate}, 32'h7FFF);

    // Timeout on the third data byte of the next frame
    clear_logs();
    drop_sel = 4;
    rx_q = '{8'h00, 8'h11, 8'h22};
    begin
      int i = 0;
      while (!err && i < 1000) begin
        wait_cycles(1);
        i++;
      end
    end
    check_output("to_err", {31'd0, err}, 32'd1);
    check_output("to_starts", st_q.size(), 4);
    check_output("to_when", err_cyc - st_at(3), 101);
    check_output("to_ss", {31'd0, spi_ss}, 32'd1);
    check_output("to_cfg_done", {31'd0, cfg_done}, 32'd0);
    check_output("to_x", {16'd0, x_rate}, 32'hBEEF);
    check_output("to_yz", {y_rate, z_rate}, 32'h00017FFF);
    enable = 1'b0;
    clear_logs();
    rx_q.delete();
    wait_cfg(500, "to_recfg");
    check_cfg_seq("to_cfg");
    check_output("to_restart_lat", st_at(0) - err_cyc, 11);
    check_output("to_err_sticky", {31'd0, err}, 32'd1);
    check_output("to_x_kept", {16'd0, x_rate}, 32'hBEEF);

    // Reset during the fourth data byte
    wait_cycles(3);
    clear_logs();
    rx_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    enable = 1'b1;
    begin
      int i = 0;
      while (tx_q.size() < 5 && i < 500) begin
        wait_cycles(1);
        i++;
      end
    end
    check_output("mid_byte4", {31'd0, tx_q.size() >= 5}, 32'd1);
    wait_cycles(10);
    rst = 1'b1;
    enable = 1'b0;
    clear_logs();
    wait_cycles(1);
    check_output("mid_ss", {31'd0, spi_ss}, 32'd1);
    check_output("mid_xyz", {x_rate, y_rate | z_rate}, 32'd0);
    check_output("mid_flags", {29'd0, sample_valid, cfg_done, err}, 32'd0);
    wait_cycles(3);
    check_output("mid_no_start", tx_q.size(), 0);
    rel = cyc;
    clear_logs();
    rx_q.delete();
    rst = 1'b0;
    wait_cfg(500, "mid_recfg");
    check_cfg_seq("mid_cfg");
    check_output("mid_latency", st_at(0) - rel, 11);

    // Every done lands exactly on timeout expiry
    wait_cycles(3);
    eng_delay = 100;
    valid_cnt = 0;
    rx_q = '{8'h00, 8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05};
    enable = 1'b1;
    wait_valid(1500, "co_valid");
    check_output("co_err", {31'd0, err}, 32'd0);
    check_output("co_cfg_done", {31'd0, cfg_done}, 32'd1);
    check_output("co_x", {16'd0, x_rate}, 32'h0102);
    check_output("co_y", {16'd0, y_rate}, 32'h0304);
    check_output("co_z", {16'd0, z_rate}, 32'h0506);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
